// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown controller.
package countdown_pkg;

  // Default width of the count and load value
  localparam int DW_DEFAULT = 8;

  // Controller states; the encoding is visible on state_o for debug
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/down_cnt_core.sv
// Loadable down counter that never wraps below zero.
// Priority: clr, then load, then dec.
module down_cnt_core #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          dec,
  input  logic          clr,
  output logic [DW-1:0] count
);

  logic [DW-1:0] count_reg;

  // Counter register: clear, load or saturating decrement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - DW'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown controller: IDLE/RUN/HOLD/DONE FSM with pause, abort and
// auto-reload. The count itself lives in down_cnt_core; this module owns
// the FSM and the reload register.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] load_val,
  input  logic          tick,
  input  logic          pause,
  input  logic          abort,
  input  logic          reload_en,
  output logic [DW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_o
);

  state_t        state_reg;
  state_t        state_next;
  logic [DW-1:0] reload_reg;

  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_clr;
  logic [DW-1:0] cnt_load_val;
  logic          reload_capture;
  logic          count_le_one;
  logic          reload_nonzero;

  // A tick at count 1 (or the unreachable count 0) ends the run
  assign count_le_one   = (count <= DW'(1));
  assign reload_nonzero = (reload_reg != '0);

  down_cnt_core #(
    .DW(DW)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .count    (count)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Reload register: captures the start value whenever a start is honoured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_reg <= '0;
    end else if (reload_capture) begin
      reload_reg <= load_val;
    end
  end

  // Next-state logic; abort beats pause beats tick
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (load_val != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (pause) begin
          state_next = ST_HOLD;
        end else if (tick && count_le_one) begin
          state_next = ST_DONE;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (!pause) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!abort && reload_en && reload_nonzero) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: counter controls, reload capture and status flags
  always_comb begin
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_clr        = 1'b0;
    cnt_load_val   = load_val;
    reload_capture = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cnt_load       = 1'b1;
          reload_capture = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          cnt_clr = 1'b1;
        end else if (!pause && tick) begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        // Ticks are dropped while holding and on the exit cycle
        if (abort) begin
          cnt_clr = 1'b1;
        end
      end
      ST_DONE: begin
        if (!abort && reload_en && reload_nonzero) begin
          cnt_load     = 1'b1;
          cnt_load_val = reload_reg;
        end
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign state_o = state_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed, table-driven bench for countdown_ctrl. Each vector holds the
// inputs for one clock cycle and the outputs expected after that edge.
module tb_countdown_ctrl;

  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] load_val;
  logic          tick;
  logic          pause;
  logic          abort;
  logic          reload_en;
  logic [DW-1:0] count;
  logic          busy;
  logic          done;
  logic [1:0]    state_o;

  countdown_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_val  (load_val),
    .tick      (tick),
    .pause     (pause),
    .abort     (abort),
    .reload_en (reload_en),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] lv;
    logic          tick;
    logic          pause;
    logic          abort;
    logic          rel;
    logic [DW-1:0] ecount;
    logic          ebusy;
    logic          edone;
    logic [1:0]    estate;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_err;

  // state encodings
  localparam logic [1:0] I = 2'd0, R = 2'd1, H = 2'd2, D = 2'd3;

  task automatic add(input string name, input logic rst_n, input logic st,
                     input int lv, input logic tk, input logic ps,
                     input logic ab, input logic rl, input int ec,
                     input logic [1:0] es);
    vec_t v;
    v.name   = name;
    v.rst_n  = rst_n;
    v.start  = st;
    v.lv     = DW'(lv);
    v.tick   = tk;
    v.pause  = ps;
    v.abort  = ab;
    v.rel    = rl;
    v.ecount = DW'(ec);
    v.estate = es;
    v.ebusy  = (es != I);
    v.edone  = (es == D);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] ec,
                       input logic eb, input logic ed, input logic [1:0] es);
    n_vec++;
    if (count !== ec || busy !== eb || done !== ed || state_o !== es) begin
      n_err++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b state=%0d, want count=%0d busy=%0b done=%0b state=%0d",
               name, count, busy, done, state_o, ec, eb, ed, es);
    end else begin
      $display("vec %0d %s: count=%0d busy=%0b done=%0b state=%0d ok",
               n_vec, name, count, busy, done, state_o);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0; start = 1'b0; load_val = '0; tick = 1'b0;
    pause = 1'b0; abort = 1'b0; reload_en = 1'b0;

    //   name          rst st lv tk ps ab rl  cnt st
    add("reset",       0, 0, 0, 0, 0, 0, 0,  0, I);
    add("reset_start", 0, 1, 3, 1, 0, 0, 0,  0, I);
    // basic countdown from 3 with continuous ticks
    add("a_load3",     1, 1, 3, 1, 0, 0, 0,  3, R);
    add("a_dec2",      1, 0, 0, 1, 0, 0, 0,  2, R);
    add("a_dec1",      1, 0, 0, 1, 0, 0, 0,  1, R);
    add("a_done",      1, 0, 0, 1, 0, 0, 0,  0, D);
    add("a_idle",      1, 0, 0, 1, 0, 0, 0,  0, I);
    add("a_idle2",     1, 0, 0, 1, 0, 0, 0,  0, I);
    // load 5, pause 4 cycles at count 4 while ticking
    add("b_load5",     1, 1, 5, 1, 0, 0, 0,  5, R);
    add("b_dec4",      1, 0, 0, 1, 0, 0, 0,  4, R);
    add("b_hold1",     1, 0, 0, 1, 1, 0, 0,  4, H);
    add("b_hold2",     1, 1, 9, 1, 1, 0, 0,  4, H);
    add("b_hold3",     1, 0, 0, 1, 1, 0, 0,  4, H);
    add("b_hold4",     1, 0, 0, 1, 1, 0, 0,  4, H);
    add("b_exit",      1, 0, 0, 1, 0, 0, 0,  4, R);
    add("b_dec3",      1, 0, 0, 1, 0, 0, 0,  3, R);
    add("b_dec2",      1, 0, 0, 1, 0, 0, 0,  2, R);
    add("b_dec1",      1, 0, 0, 1, 0, 0, 0,  1, R);
    add("b_done",      1, 0, 0, 1, 0, 0, 0,  0, D);
    add("b_idle",      1, 0, 0, 1, 0, 0, 0,  0, I);
    // auto-reload from 2
    add("c_load2",     1, 1, 2, 1, 0, 0, 1,  2, R);
    add("c_dec1",      1, 0, 0, 1, 0, 0, 1,  1, R);
    add("c_done1",     1, 0, 0, 1, 0, 0, 1,  0, D);
    add("c_reload1",   1, 0, 0, 1, 0, 0, 1,  2, R);
    add("c_dec1b",     1, 0, 0, 1, 0, 0, 1,  1, R);
    add("c_done2",     1, 0, 0, 1, 0, 0, 1,  0, D);
    add("c_reload2",   1, 0, 0, 1, 0, 0, 1,  2, R);
    add("c_dec1c",     1, 0, 0, 1, 0, 0, 0,  1, R);
    add("c_done3",     1, 0, 0, 1, 0, 0, 0,  0, D);
    add("c_idle",      1, 0, 0, 1, 0, 0, 0,  0, I);
    // abort in RUN at count 7 (abort beats pause and tick)
    add("d_load7",     1, 1, 7, 0, 0, 0, 0,  7, R);
    add("d_tick0",     1, 0, 0, 0, 0, 0, 0,  7, R);
    add("d_abort_run", 1, 0, 0, 1, 1, 1, 0,  0, I);
    add("d_no_done",   1, 0, 0, 0, 0, 0, 0,  0, I);
    // abort in HOLD at count 7
    add("e_load7",     1, 1, 7, 0, 0, 0, 0,  7, R);
    add("e_hold",      1, 0, 0, 1, 1, 0, 0,  7, H);
    add("e_abort_hld", 1, 0, 0, 1, 1, 1, 0,  0, I);
    add("e_no_done",   1, 0, 0, 0, 0, 0, 0,  0, I);
    // zero load goes straight to DONE, even with reload_en
    add("f_load0",     1, 1, 0, 1, 0, 0, 1,  0, D);
    add("f_idle",      1, 0, 0, 1, 0, 0, 1,  0, I);
    // start ignored in RUN
    add("g_load6",     1, 1, 6, 0, 0, 0, 0,  6, R);
    add("g_start_run", 1, 1, 9, 0, 0, 0, 0,  6, R);
    add("g_start_tk",  1, 1, 9, 1, 0, 0, 0,  5, R);
    add("g_abort",     1, 0, 0, 0, 0, 1, 0,  0, I);
    // abort in DONE overrides reload
    add("h_load1",     1, 1, 1, 0, 0, 0, 1,  1, R);
    add("h_done",      1, 0, 0, 1, 0, 0, 1,  0, D);
    add("h_abort_dn",  1, 0, 0, 0, 0, 1, 1,  0, I);
    // reset mid-countdown: no resume; first edge after release honours start
    add("r_load5",     1, 1, 5, 1, 0, 0, 1,  5, R);
    add("r_dec4",      1, 0, 0, 1, 0, 0, 1,  4, R);
    add("r_reset",     0, 0, 0, 1, 0, 0, 1,  0, I);
    add("r_no_resume", 1, 0, 0, 1, 0, 0, 1,  0, I);
    add("r_reset2",    0, 1, 2, 0, 0, 0, 0,  0, I);
    add("r_first_st",  1, 1, 2, 0, 0, 0, 0,  2, R);
    add("r_abort",     1, 0, 0, 0, 0, 1, 0,  0, I);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset     = vq[i].rst_n;
      start     = vq[i].start;
      load_val  = vq[i].lv;
      tick      = vq[i].tick;
      pause     = vq[i].pause;
      abort     = vq[i].abort;
      reload_en = vq[i].rel;
      @(posedge clk);
      #1;
      check(vq[i].name, vq[i].ecount, vq[i].ebusy, vq[i].edone, vq[i].estate);
    end

    // Asynchronous reset between edges with count 4
    @(negedge clk);
    reset = 1'b1; start = 1'b1; load_val = DW'(4); tick = 1'b0;
    pause = 1'b0; abort = 1'b0; reload_en = 1'b0;
    @(posedge clk);
    #1;
    check("async_pre", DW'(4), 1'b1, 1'b0, R);
    @(negedge clk);
    start = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_mid", DW'(0), 1'b0, 1'b0, I);
    @(posedge clk);
    #1;
    check("async_hold", DW'(0), 1'b0, 1'b0, I);
    @(negedge clk);
    reset = 1'b1; tick = 1'b1;
    @(posedge clk);
    #1;
    check("async_after", DW'(0), 1'b0, 1'b0, I);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
